// File: rtl/exec_dispatch_if.sv
// Issue, exec-element and write-back signals of exec_dispatch.
// slave = the dispatcher; master = the surrounding pipeline/element/register file.
interface exec_dispatch_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_pc;
  logic [5:0]  issue_inst_num;
  logic [4:0]  issue_rd;
  logic [15:0] issue_const16;
  logic [31:0] issue_rs;
  logic [31:0] issue_rt;

  logic        elem_reset;
  logic [31:0] elem_pc;
  logic [5:0]  elem_inst_num;
  logic [15:0] elem_const16;
  logic [31:0] elem_const16_x;
  logic [31:0] elem_rs;
  logic [31:0] elem_rt;
  logic        elem_completed;
  logic [31:0] elem_out;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        timeout_err;

  modport master (
    output issue_valid, issue_pc, issue_inst_num, issue_rd, issue_const16, issue_rs, issue_rt,
    output elem_completed, elem_out, wb_ready,
    input  issue_ready, elem_reset, elem_pc, elem_inst_num, elem_const16, elem_const16_x,
    input  elem_rs, elem_rt, wb_valid, wb_rd, wb_data, timeout_err
  );

  modport slave (
    input  issue_valid, issue_pc, issue_inst_num, issue_rd, issue_const16, issue_rs, issue_rt,
    input  elem_completed, elem_out, wb_ready,
    output issue_ready, elem_reset, elem_pc, elem_inst_num, elem_const16, elem_const16_x,
    output elem_rs, elem_rt, wb_valid, wb_rd, wb_data, timeout_err
  );
endinterface

// File: rtl/exec_dispatch.sv
// Dispatches one decoded instruction at a time to an exec element and writes its result back.
// Optional WAIT abort with sticky timeout_err when EXEC_DISPATCH_TIMEOUT_EN is defined.
module exec_dispatch #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic            clk,
  input logic            reset,
  exec_dispatch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;
  state_t state, state_nxt;

  logic [31:0] pc_q, rs_q, rt_q, wb_data_q;
  logic [5:0]  inst_num_q;
  logic [4:0]  rd_q;
  logic [15:0] const16_q;
  logic        wait_first;
  logic        handshake;
  logic        done;
  logic        timed_out;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("exec_dispatch: TIMEOUT_CYCLES must be nonzero");
  end

  assign bus.issue_ready = (state == IDLE) && !reset;
  assign handshake       = bus.issue_valid && bus.issue_ready;
  // The element is still settling from its restart in the first WAIT cycle.
  assign done            = (state == WAIT) && !wait_first && bus.elem_completed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.elem_reset = 1'b0;
    bus.wb_valid   = 1'b0;
    unique case (state)
      IDLE:  if (handshake) state_nxt = START;
      START: begin
        bus.elem_reset = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        if (done)           state_nxt = (rd_q == '0) ? IDLE : WB;
        else if (timed_out) state_nxt = IDLE;
      end
      WB: begin
        bus.wb_valid = 1'b1;
        if (bus.wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      inst_num_q <= '0;
      rd_q       <= '0;
      const16_q  <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      wait_first <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      if (handshake) begin
        pc_q       <= bus.issue_pc;
        inst_num_q <= bus.issue_inst_num;
        rd_q       <= bus.issue_rd;
        const16_q  <= bus.issue_const16;
        rs_q       <= bus.issue_rs;
        rt_q       <= bus.issue_rt;
      end
      wait_first <= (state == START);
      if (done) wb_data_q <= bus.elem_out;
    end
  end

  assign bus.elem_pc        = pc_q;
  assign bus.elem_inst_num  = inst_num_q;
  assign bus.elem_const16   = const16_q;
  assign bus.elem_const16_x = {{16{const16_q[15]}}, const16_q};
  assign bus.elem_rs        = rs_q;
  assign bus.elem_rt        = rt_q;
  assign bus.wb_rd          = rd_q;
  assign bus.wb_data        = wb_data_q;

`ifdef EXEC_DISPATCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // Counter holds the number of completed WAIT cycles; it never wraps since WAIT exits at the limit.
  assign timed_out = (state == WAIT) && !done && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == START)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (timed_out) err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = err_q;
`else
  assign timed_out       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_exec_dispatch.sv
// Scoreboard bench for exec_dispatch: directed timing cases followed by randomized traffic
// against a behavioural exec element and a field-level result model.
module tb_exec_dispatch;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exec_dispatch_if bus();
  exec_dispatch #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_t;
  wb_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  bit          auto_elem = 1'b0;
  bit          rand_wbr  = 1'b0;
  int          elem_lat  = 0;
  logic        m_completed = 1'b0, d_completed = 1'b0;
  logic        r_wbr = 1'b0, d_wbr = 1'b0;
  logic [31:0] m_out = '0, d_out = '0;

  assign bus.elem_completed = auto_elem ? m_completed : d_completed;
  assign bus.elem_out       = auto_elem ? m_out : d_out;
  assign bus.wb_ready       = rand_wbr ? r_wbr : d_wbr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Result the behavioural element produces, computed from the issued fields.
  function automatic logic [31:0] model_result(input logic [31:0] pc, input logic [5:0] num,
                                               input logic [15:0] c, input logic [31:0] rs,
                                               input logic [31:0] rt);
    logic signed [31:0] cx;
    cx = 32'($signed(c));
    return (rs + rt + cx) ^ pc ^ {26'd0, num};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_issue(input logic [31:0] pc, input logic [5:0] num, input logic [4:0] rd,
                             input logic [15:0] c, input logic [31:0] rs, input logic [31:0] rt);
    bus.issue_valid    = 1'b1;
    bus.issue_pc       = pc;
    bus.issue_inst_num = num;
    bus.issue_rd       = rd;
    bus.issue_const16  = c;
    bus.issue_rs       = rs;
    bus.issue_rt       = rt;
  endtask

  // Behavioural exec element: restarts on elem_reset, raises completed elem_lat cycles later and holds it.
  initial begin
    int cnt;
    cnt = -1;
    forever begin
      mid();
      if (reset || bus.elem_reset) begin
        m_completed = 1'b0;
        cnt = reset ? -1 : elem_lat;
      end else if (cnt == 0) begin
        m_out = (bus.elem_rs + bus.elem_rt + bus.elem_const16_x) ^ bus.elem_pc ^ {26'd0, bus.elem_inst_num};
        m_completed = 1'b1;
        cnt = -1;
      end else if (cnt > 0) begin
        cnt--;
      end
    end
  end

  initial forever begin
    step();
    r_wbr = ($urandom_range(0, 2) != 0);
  end

  // Monitor: every accepted write-back must match the oldest expected result.
  initial forever begin
    mid();
    if (!reset && bus.wb_valid === 1'b1 && bus.wb_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected: got rd %0d data %0h expected no write-back", bus.wb_rd, bus.wb_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
        chk("wb_data", 64'(bus.wb_data), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive_issue('0, '0, '0, '0, '0, '0);
    bus.issue_valid = 1'b0;
    #2;
    chk("rst_issue_ready", 64'(bus.issue_ready), 0);
    chk("rst_elem_reset", 64'(bus.elem_reset), 0);
    chk("rst_wb_valid", 64'(bus.wb_valid), 0);
    chk("rst_wb_rd", 64'(bus.wb_rd), 0);
    chk("rst_wb_data", 64'(bus.wb_data), 0);
    chk("rst_timeout_err", 64'(bus.timeout_err), 0);
    chk("rst_elem_rs", 64'(bus.elem_rs), 0);
    repeat (2) step();
    reset = 1'b0;
    mid();
    chk("first_cycle_ready", 64'(bus.issue_ready), 1);

    // Basic dispatch and T+4 latency, element returns 3.
    d_wbr = 1'b1;
    step(); drive_issue(32'h100, 6'd9, 5'd3, 16'hFFFE, 32'd5, 32'd0);
    exp_q.push_back('{5'd3, 32'd3});
    mid(); chk("issue_ready_idle", 64'(bus.issue_ready), 1);
    step(); bus.issue_valid = 1'b0; mid();
    chk("elem_reset_start", 64'(bus.elem_reset), 1);
    chk("elem_const16_x", 64'(bus.elem_const16_x), 64'h0000_0000_FFFF_FFFE);
    chk("elem_inst_num", 64'(bus.elem_inst_num), 9);
    chk("elem_rs", 64'(bus.elem_rs), 5);
    chk("issue_ready_busy", 64'(bus.issue_ready), 0);
    step(); mid(); chk("elem_reset_pulse", 64'(bus.elem_reset), 0);
    step(); d_completed = 1'b1; d_out = 32'd3; mid();
    chk("wb_valid_early", 64'(bus.wb_valid), 0);
    step(); d_completed = 1'b0; mid();
    chk("wb_valid_t4", 64'(bus.wb_valid), 1);
    step(); mid();
    chk("idle_after_wb", 64'(bus.issue_ready), 1);
    chk("wb_valid_after", 64'(bus.wb_valid), 0);

    // Write-back back-pressure: outputs hold for 5 cycles, release one cycle after wb_ready.
    d_wbr = 1'b0;
    step(); drive_issue(32'h200, 6'd1, 5'd17, 16'h1234, 32'd9, 32'd1);
    exp_q.push_back('{5'd17, 32'hCAFE0001});
    step(); bus.issue_valid = 1'b0;
    step();
    step(); d_completed = 1'b1; d_out = 32'hCAFE0001;
    step(); d_completed = 1'b0; d_out = 32'hDEAD0000;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("hold_wb_valid", 64'(bus.wb_valid), 1);
      chk("hold_wb_rd", 64'(bus.wb_rd), 17);
      chk("hold_wb_data", 64'(bus.wb_data), 64'h0000_0000_CAFE_0001);
      step();
    end
    d_wbr = 1'b1;
    mid(); chk("wb_valid_release", 64'(bus.wb_valid), 1);
    step(); mid(); chk("idle_after_release", 64'(bus.issue_ready), 1);

    // rd = 0 completes without a write-back.
    step(); drive_issue(32'h300, 6'd2, 5'd0, 16'h0001, 32'd7, 32'd7);
    step(); bus.issue_valid = 1'b0; mid(); chk("rd0_elem_reset", 64'(bus.elem_reset), 1);
    step();
    step(); d_completed = 1'b1;
    step(); d_completed = 1'b0; mid();
    chk("rd0_idle", 64'(bus.issue_ready), 1);
    for (int i = 0; i < 3; i++) begin
      mid(); chk("rd0_no_wb", 64'(bus.wb_valid), 0);
      step();
    end

    // Asynchronous reset while waiting discards the instruction.
    step(); drive_issue(32'h400, 6'd3, 5'd7, 16'h8000, 32'h55, 32'h1);
    step(); bus.issue_valid = 1'b0;
    step(); mid();
    #1 reset = 1'b1;
    #1;
    chk("arst_issue_ready", 64'(bus.issue_ready), 0);
    chk("arst_wb_valid", 64'(bus.wb_valid), 0);
    chk("arst_wb_data", 64'(bus.wb_data), 0);
    chk("arst_elem_rs", 64'(bus.elem_rs), 0);
    chk("arst_const16_x", 64'(bus.elem_const16_x), 0);
    chk("arst_elem_pc", 64'(bus.elem_pc), 0);
    step(); step(); mid();
    chk("held_reset_ready", 64'(bus.issue_ready), 0);
    step(); reset = 1'b0; d_completed = 1'b1; mid();
    chk("post_reset_ready", 64'(bus.issue_ready), 1);
    for (int i = 0; i < 4; i++) begin
      step(); mid(); chk("post_reset_no_wb", 64'(bus.wb_valid), 0);
    end
    d_completed = 1'b0;

    // Completion held high before issue is ignored in the first WAIT cycle.
    step(); d_completed = 1'b1; d_out = 32'h0BADF00D;
    drive_issue(32'h500, 6'd4, 5'd4, 16'h0010, 32'd2, 32'd3);
    exp_q.push_back('{5'd4, 32'h0BADF00D});
    step(); bus.issue_valid = 1'b0;
    step(); mid(); chk("held_first_wait", 64'(bus.wb_valid), 0);
    step(); mid(); chk("held_second_wait", 64'(bus.wb_valid), 0);
    step(); mid(); chk("held_wb_t4", 64'(bus.wb_valid), 1);
    step(); d_completed = 1'b0;

    // Randomized traffic.
    auto_elem = 1'b1;
    rand_wbr  = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] pc, rs, rt;
      logic [5:0]  num;
      logic [4:0]  rd;
      logic [15:0] c;
      int          guard;
      pc  = $urandom;
      rs  = $urandom;
      rt  = $urandom;
      num = 6'($urandom);
      c   = 16'($urandom);
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      elem_lat = $urandom_range(0, 4);
      drive_issue(pc, num, rd, c, rs, rt);
      guard = 0;
      mid();
      while (bus.issue_ready !== 1'b1 && guard < 100) begin
        step(); mid(); guard++;
      end
      if (guard >= 100) begin
        n_cmp++; n_bad++;
        $display("FAIL issue_timeout: got no issue_ready expected handshake within 100 cycles");
        break;
      end
      if (rd != 5'd0) exp_q.push_back('{rd, model_result(pc, num, c, rs, rt)});
      step();
      if ($urandom_range(0, 2) == 0) begin
        bus.issue_valid = 1'b0;
        repeat ($urandom_range(1, 4)) step();
      end
    end
    bus.issue_valid = 1'b0;
    for (int g = 0; g < 300 && exp_q.size() != 0; g++) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    rand_wbr = 1'b0;
    d_wbr = 1'b1;
    repeat (10) step();
    auto_elem = 1'b0;
    d_completed = 1'b0;

`ifdef EXEC_DISPATCH_TIMEOUT_EN
    step(); drive_issue(32'h600, 6'd5, 5'd2, 16'h0, 32'd1, 32'd1);
    step(); bus.issue_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(); mid();
      chk("to_not_yet", 64'(bus.timeout_err), 0);
      chk("to_no_wb", 64'(bus.wb_valid), 0);
    end
    step(); mid();
    chk("to_err_set", 64'(bus.timeout_err), 1);
    chk("to_idle", 64'(bus.issue_ready), 1);
    chk("to_wb_valid", 64'(bus.wb_valid), 0);
`else
    mid();
    chk("timeout_err_tied", 64'(bus.timeout_err), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exec_dispatch.md
EXEC_DISPATCH -- requirements
Module: exec_dispatch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles spent in WAIT before abort (used only with EXEC_DISPATCH_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 issue_valid  in  1  upstream holds a decoded instruction.
REQ-005 issue_ready  out  1  dispatcher accepts an instruction this cycle.
REQ-006 issue_pc / issue_inst_num / issue_rd / issue_const16 / issue_rs / issue_rt  in  32/6/5/16/32/32  instruction fields and operand values.
REQ-007 elem_reset  out  1  synchronous restart pulse to the exec element.
REQ-008 elem_pc / elem_inst_num / elem_const16 / elem_const16_x / elem_rs / elem_rt  out  32/6/16/32/32/32  latched operands to the exec element.
REQ-009 elem_completed  in  1  exec element finished; elem_out is valid.
REQ-010 elem_out  in  32  exec element result.
REQ-011 wb_valid  out  1  write-back request pending.
REQ-012 wb_ready  in  1  register file accepts write-back.
REQ-013 wb_rd / wb_data  out  5/32  destination register and result.
REQ-014 timeout_err  out  1  sticky abort flag (EXEC_DISPATCH_TIMEOUT_EN only; constant 0 otherwise).

Function
REQ-015 FSM states IDLE, START, WAIT, WB; reset state IDLE.
REQ-016 issue_ready = 1 only in IDLE; issue handshake = issue_valid & issue_ready.
REQ-017 IDLE: on handshake latch all issue_* fields, go START; otherwise stay.
REQ-018 elem_const16_x = sign extension of latched const16 (bit 15 replicated into bits 31:16); elem_* outputs driven from latches and stable from START until next handshake.
REQ-019 START: elem_reset = 1 for exactly this one cycle, go WAIT; elem_reset = 0 in all other states.
REQ-020 WAIT: elem_completed ignored in the first WAIT cycle; from second WAIT cycle on, elem_completed = 1 captures elem_out into wb_data and goes WB.
REQ-021 Latency: handshake in cycle T, single-cycle element (completed at T+3) -> wb_valid = 1 in cycle T+4.
REQ-022 WB: wb_valid = 1, wb_rd = latched rd; hold wb_data/wb_rd stable until wb_ready = 1, then go IDLE.
REQ-023 rd = 0: WAIT still completes, but WB is skipped (WAIT -> IDLE directly) and wb_valid never asserts.
REQ-024 wb_ready high while not in WB has no effect; issue_valid held high continuously yields back-to-back dispatch with one IDLE cycle between instructions.

Reset
REQ-025 reset asserted in any state forces IDLE immediately, independent of clk.
REQ-026 Reset values: issue_ready 0 while reset held, elem_reset 0, wb_valid 0, wb_rd 0, wb_data 0, timeout_err 0, all operand latches 0.
REQ-027 Reset mid-operation discards the in-flight instruction; no write-back occurs for it.
REQ-028 First cycle after reset deassertion: state IDLE, issue_ready = 1.

Configuration
REQ-029 Macro EXEC_DISPATCH_TIMEOUT_EN defined: cycle counter cleared on WAIT entry; if TIMEOUT_CYCLES elapse in WAIT without elem_completed, set timeout_err (sticky until reset), return to IDLE, no write-back.
REQ-030 Macro undefined: no counter; WAIT waits indefinitely; timeout_err tied to 0.

Verification
REQ-031 Issue inst_num 9, rd 3, const16 0xFFFE, rs 5; element returns 3 -> elem_const16_x = 0xFFFFFFFE, elem_reset one pulse, wb_valid at T+4, wb_rd 3, wb_data 3.
REQ-032 Same with wb_ready held 0 for 5 cycles -> wb_valid, wb_rd, wb_data stable all 5 cycles; IDLE one cycle after wb_ready = 1.
REQ-033 Issue with rd 0 -> element pulsed and completes; wb_valid stays 0; issue_ready returns to 1.
REQ-034 Reset asserted during WAIT -> outputs at reset values without clock edge; elem_completed afterwards produces no wb_valid.
REQ-035 elem_completed held 1 from before issue -> not captured in first WAIT cycle; captured only from second WAIT cycle.
REQ-036 With EXEC_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES 8, elem_completed held 0 -> timeout_err = 1 after 8 WAIT cycles, state IDLE, wb_valid never asserted.
